// File: rtl/seg_scanner_if.sv
// seg_scanner_if: signal bundle between a display-data producer and the
// seg_scanner digit multiplexer.
//
// Parameters
//   DIGITS : number of digits carried (data is 4*DIGITS bits)
//   SEL_W  : width of the digit slot index
//
// Signals
//   load       producer -> scanner  capture strobe for data/dp/blank
//   data       producer -> scanner  hex nibble per digit, digit i = data[4i+3:4i]
//   dp         producer -> scanner  decimal point per digit, 1 = lit
//   blank      producer -> scanner  1 = digit forced dark
//   an         scanner -> display   digit enables, active-low one-hot
//   seg        scanner -> display   segments active-low, [7] = dp
//   sel        scanner -> observer  current digit slot index
//   frame_done scanner -> observer  one-cycle pulse when sel wraps to 0
//   dbg_show   scanner -> observer  scan FSM state, 1 = SHOW, 0 = GAP
//
// Handshake: there is no valid/ready pair. load is a plain strobe sampled on
// every rising clock edge; the scanner always accepts it, so there is no
// back-pressure and the producer never waits.
interface seg_scanner_if #(
  parameter int DIGITS = 8,
  parameter int SEL_W  = 3
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS-1:0]     an;
  logic [7:0]            seg;
  logic [SEL_W-1:0]      sel;
  logic                  frame_done;
  logic                  dbg_show;

  modport master (
    output load, data, dp, blank,
    input  an, seg, sel, frame_done, dbg_show
  );

  modport slave (
    input  load, data, dp, blank,
    output an, seg, sel, frame_done, dbg_show
  );
endinterface

// File: rtl/seg_scanner.sv
// seg_scanner: multiplexed seven-segment display driver.
//
// Keeps a shadow copy of DIGITS hex nibbles, decimal points and blank flags,
// and lights one digit at a time for PRESCALE cycles, separated by GAP_CYC
// all-off cycles to stop ghosting. Hex is decoded to segments internally and
// frame_done pulses once per full scan. Every output is registered.
//
// Ports
//   clk    in  rising-edge system clock
//   reset  in  asynchronous active-low reset
//   bus    seg_scanner_if.slave (load/data/dp/blank in; an/seg/sel/
//          frame_done/dbg_show out)
//
// Optional build macro
//   LEAD_ZERO_BLANK_EN : when defined, leading zero digits (all higher digits
//   also zero, digit 0 excepted) are shown dark, keeping their dp.
module seg_scanner #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 1000,
  parameter int GAP_CYC  = 2,
  parameter int SEL_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  seg_scanner_if.slave bus
);

  localparam int CMAX  = (PRESCALE > GAP_CYC) ? PRESCALE : GAP_CYC;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  typedef enum logic {ST_GAP = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    fd_q, fd_d;
  logic [DIGITS-1:0][3:0]  nib_q;
  logic [DIGITS-1:0]       dp_q;
  logic [DIGITS-1:0]       blank_q;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Segment pattern for a slot, taken from the shadow as it stands before the
  // slot-start edge, so a load on that same edge only shows from the next slot.
  function automatic logic [7:0] slot_seg(input logic [SEL_W-1:0] idx);
    logic [7:0] s;
    s = {~dp_q[idx], hex7(nib_q[idx])};
`ifdef LEAD_ZERO_BLANK_EN
    begin : lead_zero
      logic lz;
      lz = (idx != '0);
      for (int i = 0; i < DIGITS; i++) begin
        if (i >= int'(idx) && nib_q[i] != 4'h0) lz = 1'b0;
      end
      // Auto-blanked digits keep their decimal point.
      if (lz) s[6:0] = 7'h7F;
    end
`endif
    if (blank_q[idx]) s = 8'hFF;
    return s;
  endfunction

  function automatic logic [DIGITS-1:0] an_for(input logic [SEL_W-1:0] idx);
    return ~(DIGITS'(1) << idx);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    an_d    = an_q;
    seg_d   = seg_q;
    fd_d    = 1'b0;
    case (state_q)
      ST_GAP: begin
        an_d  = '1;
        seg_d = 8'hFF;
        // With no gap configured, the reset state exits on the first edge.
        if (GAP_CYC == 0 || int'(cnt_q) == GAP_CYC - 1) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          an_d    = an_for(sel_q);
          seg_d   = slot_seg(sel_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (int'(cnt_q) == PRESCALE - 1) begin
          sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
          fd_d  = (sel_q == SEL_LAST);
          cnt_d = '0;
          if (GAP_CYC == 0) begin
            state_d = ST_SHOW;
            an_d    = an_for(sel_d);
            seg_d   = slot_seg(sel_d);
          end else begin
            state_d = ST_GAP;
            an_d    = '1;
            seg_d   = 8'hFF;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_GAP;
      cnt_q   <= '0;
      sel_q   <= '0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nib_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (bus.load) begin
      nib_q   <= bus.data;
      dp_q    <= bus.dp;
      blank_q <= bus.blank;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.sel        = sel_q;
  assign bus.frame_done = fd_q;
  assign bus.dbg_show   = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: drives two scanner configurations from shared inputs
// (8 digits / dwell 4 / gap 2, and 4 digits / dwell 1 / no gap) and checks
// them each cycle against a timing model derived from slot arithmetic.
module tb_seg_scanner;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  seg_scanner_if #(.DIGITS(8), .SEL_W(3)) if1 ();
  seg_scanner_if #(.DIGITS(4), .SEL_W(2)) if2 ();

  seg_scanner #(.DIGITS(8), .PRESCALE(4), .GAP_CYC(2), .SEL_W(3)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  seg_scanner #(.DIGITS(4), .PRESCALE(1), .GAP_CYC(0), .SEL_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2)
  );

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [7:0] LZ_DARK = 8'hFF;
`else
  localparam logic [7:0] LZ_DARK = 8'hC0;
`endif

  // Segment table g..a, active-low, as listed for digits 0..F.
  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_nib [8];
  logic [7:0] m_dp, m_blank;
  int         t1, t2;
  logic [7:0] e_seg1, e_seg2;

  // Timing after t clock edges since reset release. The first lit edge is
  // GAP (or 1 with no gap); slots then repeat every PRE+GAP edges.
  function automatic void slot_info(input int t, input int d, input int pre,
                                    input int gap, output bit lit,
                                    output bit start, output int dig,
                                    output int sel, output bit fd);
    int l, p, m;
    l = (gap > 0) ? gap : 1;
    p = pre + gap;
    lit = 0; start = 0; dig = 0;
    if (t >= l) begin
      lit   = ((t - l) % p) < pre;
      start = ((t - l) % p) == 0;
      dig   = ((t - l) / p) % d;
    end
    m = t - l + gap;
    if (m < 0) m = 0;
    sel = (m / p) % d;
    fd  = (m > 0) && (m % (p * d) == 0);
  endfunction

  function automatic logic [7:0] m_seg(input int dig, input int d);
    logic [7:0] s;
    if (m_blank[dig]) return 8'hFF;
    s = {~m_dp[dig], DEC[m_nib[dig]]};
`ifdef LEAD_ZERO_BLANK_EN
    begin : lz_blk
      bit lz;
      lz = (dig != 0);
      for (int i = dig; i < d; i++) if (m_nib[i] != 4'h0) lz = 0;
      if (lz) s[6:0] = 7'h7F;
    end
`endif
    return s;
  endfunction

  function automatic logic [7:0] next_seg(input int t, input int d, input int pre,
                                          input int gap, input logic [7:0] prev);
    bit lit, st, fd;
    int dig, sel;
    slot_info(t, d, pre, gap, lit, st, dig, sel, fd);
    if (!lit) return 8'hFF;
    if (st) return m_seg(dig, d);
    return prev;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t1 <= 0;
      t2 <= 0;
      e_seg1 <= 8'hFF;
      e_seg2 <= 8'hFF;
      for (int i = 0; i < 8; i++) m_nib[i] <= 4'h0;
      m_dp <= '0;
      m_blank <= '0;
    end else begin
      t1 <= t1 + 1;
      t2 <= t2 + 1;
      e_seg1 <= next_seg(t1 + 1, 8, 4, 2, e_seg1);
      e_seg2 <= next_seg(t2 + 1, 4, 1, 0, e_seg2);
      if (if1.load) begin
        for (int i = 0; i < 8; i++) m_nib[i] <= if1.data[4*i +: 4];
        m_dp <= if1.dp;
        m_blank <= if1.blank;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input int t, input int d, input int pre,
                     input int gap, input logic [7:0] e_seg,
                     input logic [15:0] an, input logic [7:0] seg,
                     input int sel, input logic fd, input logic show);
    bit lit, st, efd;
    int dig, esel;
    logic [15:0] ean;
    slot_info(t, d, pre, gap, lit, st, dig, esel, efd);
    ean = 16'((32'h1 << d) - 1);
    if (lit) ean[dig] = 1'b0;
    chk({nm, ".an"}, 32'(an), 32'(ean));
    chk({nm, ".seg"}, 32'(seg), 32'(e_seg));
    chk({nm, ".sel"}, 32'(sel), 32'(esel));
    chk({nm, ".frame_done"}, 32'(fd), 32'(efd));
    chk({nm, ".state"}, 32'(show), 32'(lit));
  endtask

  always @(negedge clk) begin
    cmp("dut1", t1, 8, 4, 2, e_seg1, {8'h00, if1.an}, if1.seg, int'(if1.sel),
        if1.frame_done, if1.dbg_show);
    cmp("dut2", t2, 4, 1, 0, e_seg2, {12'h000, if2.an}, if2.seg, int'(if2.sel),
        if2.frame_done, if2.dbg_show);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic ld, input logic [31:0] d,
                            input logic [7:0] p, input logic [7:0] b);
    if1.load = ld;  if1.data = d;        if1.dp = p;      if1.blank = b;
    if2.load = ld;  if2.data = d[15:0];  if2.dp = p[3:0]; if2.blank = b[3:0];
  endtask

  task automatic load_shadow(input logic [31:0] d, input logic [7:0] p,
                             input logic [7:0] b);
    set_inputs(1'b1, d, p, b);
    tick();
    if1.load = 1'b0;
    if2.load = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] v, input string nm);
    int n;
    n = 0;
    while (if1.an !== v && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({nm, ".timeout"}, 32'(if1.an), 32'(v));
  endtask

  // Waiting for an all-off cycle first guarantees the slot started after any
  // preceding load.
  task automatic wait_fresh(input logic [7:0] v, input string nm);
    wait_an(8'hFF, nm);
    wait_an(v, nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd_cnt;
    reset = 1'b0;
    set_inputs(1'b0, '0, '0, '0);

    // Reset held with random inputs.
    repeat (5) begin
      tick();
      set_inputs(1'($urandom_range(0, 1)), $urandom(), 8'($urandom()), 8'($urandom()));
    end
    tick();
    chk("rst.an", 32'(if1.an), 32'hFF);
    chk("rst.seg", 32'(if1.seg), 32'hFF);
    chk("rst.sel", 32'(if1.sel), 32'h0);
    chk("rst.frame_done", 32'(if1.frame_done), 32'h0);
    chk("rst.an2", 32'(if2.an), 32'hF);

    // Release: dut1 lights digit 0 after exactly two edges, dut2 after one.
    set_inputs(1'b0, '0, '0, '0);
    reset = 1'b1;
    tick();
    chk("rel.edge1.an", 32'(if1.an), 32'hFF);
    chk("rel.edge1.an2", 32'(if2.an), 32'hE);
    tick();
    chk("rel.edge2.an", 32'(if1.an), 32'hFE);
    chk("rel.edge2.seg", 32'(if1.seg), 32'hC0);
    chk("rel.edge2.an2", 32'(if2.an), 32'hD);
    tick();
    chk("rel.edge3.an2", 32'(if2.an), 32'hB);
    tick();
    chk("rel.edge4.an2", 32'(if2.an), 32'h7);
    tick();
    chk("rel.edge5.an2", 32'(if2.an), 32'hE);
    chk("rel.edge5.fd2", 32'(if2.frame_done), 32'h1);

    // Scan timing with an ascending pattern.
    load_shadow(32'h76543210, 8'h00, 8'h00);
    wait_fresh(8'hF7, "scan.d3");
    chk("scan.d3.seg", 32'(if1.seg), 32'hB0);
    fd_cnt = 0;
    repeat (96) begin
      tick();
      if (if1.frame_done) fd_cnt++;
    end
    chk("scan.frame_pulses", 32'(fd_cnt), 32'd2);

    // Decimal point and blanking.
    load_shadow(32'hF0000008, 8'h01, 8'h80);
    wait_fresh(8'hFE, "dpblank.d0");
    chk("dpblank.d0.seg", 32'(if1.seg), 32'h00);
    wait_fresh(8'h7F, "dpblank.d7");
    chk("dpblank.d7.seg", 32'(if1.seg), 32'hFF);

    // Load in the middle of a lit slot.
    load_shadow(32'h76543210, 8'h00, 8'h00);
    wait_fresh(8'hFB, "midload.d2");
    load_shadow(32'h76543E10, 8'h00, 8'h00);
    chk("midload.hold.an", 32'(if1.an), 32'hFB);
    chk("midload.hold.seg", 32'(if1.seg), 32'hA4);
    wait_fresh(8'hFB, "midload.next");
    chk("midload.next.seg", 32'(if1.seg), 32'h86);

    // Leading-zero suppression (dark only in the feature build).
    load_shadow(32'h00000450, 8'h00, 8'h00);
    wait_fresh(8'hF7, "lz.d3");
    chk("lz.d3.seg", 32'(if1.seg), 32'(LZ_DARK));
    wait_fresh(8'hFB, "lz.d2");
    chk("lz.d2.seg", 32'(if1.seg), 32'h99);
    wait_fresh(8'h7F, "lz.d7");
    chk("lz.d7.seg", 32'(if1.seg), 32'(LZ_DARK));
    load_shadow(32'h00000000, 8'h00, 8'h00);
    wait_fresh(8'hFD, "lz0.d1");
    chk("lz0.d1.seg", 32'(if1.seg), 32'(LZ_DARK));
    wait_fresh(8'hFE, "lz0.d0");
    chk("lz0.d0.seg", 32'(if1.seg), 32'hC0);

    // Randomized loads with occasional mid-scan resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0)
        set_inputs(1'b1, $urandom() >> (4 * $urandom_range(0, 8)), 8'($urandom()),
                   8'($urandom() & $urandom() & $urandom()));
      else begin
        if1.load = 1'b0;
        if2.load = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset = 1'b1;
      end
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scanner.md
Name: seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver for the board display path; the successor to the fixed 8-digit scanner.
- Holds a shadow copy of DIGITS hex nibbles plus decimal points and per-digit blanking.
- Time-multiplexes the digits with a programmable dwell time and an anti-ghosting dead gap between digits.
- Decodes hex to segments internally and pulses a frame marker once per full scan.

Parameters:
DIGITS, 8, number of digits scanned, 2..16
PRESCALE, 1000, clk cycles each digit is lit (SHOW dwell), >=1
GAP_CYC, 2, clk cycles with all digits off between digits, 0 = no gap
SEL_W, 3, width of sel, must satisfy 2**SEL_W >= DIGITS

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
load  in  1  when 1 on a rising edge, data/dp/blank are captured into shadow registers
data  in  4*DIGITS  hex nibble per digit, digit i = data[4i+3:4i]
dp  in  DIGITS  decimal point per digit, 1 = lit
blank  in  DIGITS  1 = digit i forced dark (segments and dp off)
an  out  DIGITS  digit enables, active-low one-hot, all 1 = all off
seg  out  8  segments active-low, seg[0]=a .. seg[6]=g, seg[7]=dp
sel  out  SEL_W  index of current digit slot
frame_done  out  1  one-cycle pulse when sel wraps DIGITS-1 -> 0

Behaviour:
- Reset (reset=0, asynchronous):
  - an = all 1, seg = 8'hFF, sel = 0, frame_done = 0.
  - State GAP, counter cnt = 0.
  - Shadow data, dp and blank = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Shadow capture: load=1 updates the shadow on that edge. Scanning reads only the shadow.
- States GAP and SHOW; cnt counts cycles within the current state.
- GAP:
  - an = all 1, seg = 8'hFF.
  - When cnt == GAP_CYC-1: go to SHOW, cnt = 0. On the same edge, an[sel] = 0, all other an = 1, and seg is loaded with the decode of shadow digit sel.
  - GAP_CYC = 0: GAP is never entered after reset exit. The first edge after reset goes straight to SHOW for digit 0. SHOW then returns directly to SHOW for the next digit.
- SHOW:
  - an and seg are held constant for the whole dwell. A load during SHOW does not change the lit digit until its next slot.
  - When cnt == PRESCALE-1: sel = (sel == DIGITS-1) ? 0 : sel+1, cnt = 0, then go to GAP (an = all 1, seg = 8'hFF), or go to SHOW of the next digit if GAP_CYC = 0.
  - frame_done = 1 for exactly that edge's cycle when sel wraps to 0; 0 otherwise.
- Slot period = PRESCALE + GAP_CYC cycles. Frame period = DIGITS * slot period.
- Decode, active-low, seg[6:0] listed g..a:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- seg[7] = ~dp[sel].
- blank[sel] = 1: seg = 8'hFF for the slot, but an[sel] is still driven low so timing is unchanged.
- load coinciding with a slot start: the newly captured value is NOT used for that slot. Decode uses the shadow as it stood before the edge.
- Reset mid-scan: asynchronous return to reset values. The scan restarts at digit 0 with a full GAP (or SHOW if GAP_CYC = 0) after reset release.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: digits are ordered most significant = DIGITS-1. Any digit whose nibble is 0 and where every higher digit is also 0 is blanked, as if blank=1. Digit 0 is never auto-blanked. The dp of an auto-blanked digit is still shown if dp=1. Suppression is evaluated from the shadow at slot start.
- Undefined: zeros are displayed normally; only the blank input blanks digits.

Test Plan:
1. Reset: hold reset=0 with random inputs -> an=8'hFF, seg=8'hFF, sel=0, frame_done=0. Release -> first digit lit after exactly GAP_CYC=2 cycles.
2. Scan timing: DIGITS=8, PRESCALE=4, GAP_CYC=2, load data=32'h76543210, dp=0 -> sel steps 0..7 every 6 cycles, an[i]=0 for 4 cycles per slot, 2 all-off cycles between slots. Digit 3 shows seg=8'hB0. frame_done pulses every 48 cycles, coincident with sel 7->0.
3. Decimal point and blanking: dp=8'h01, blank=8'h80, data=32'hF0000008 -> digit 0 seg=8'h00, digit 7 seg=8'hFF with an[7]=0.
4. Mid-slot load: during SHOW of digit 2 (value 2), load data nibble 2 = E -> digit 2 stays seg=8'hA4 for the slot. Next frame shows seg=8'h86.
5. GAP_CYC=0, PRESCALE=1, DIGITS=4 -> an cycles E,D,B,7 on consecutive edges with no all-off cycle. frame_done is high every 4th cycle.
6. LEAD_ZERO_BLANK_EN: data=32'h00000450 -> digits 7..3 dark, digits 2..0 show 4,5,0. data=0 -> only digit 0 lit showing "0". Without the macro, all 8 digits show their values.
